nios2_jtag_ocimem_ctrl: RTL

//  Downstream of the JTAG debug-slave sysclk stage: consumes jdo and the ocimem take_action strobes.

---
 rtl/nios2_ocimem_pkg.sv | 24 ++
 rtl/nios2_ocimem_ram.sv | 36 +++
 rtl/nios2_jtag_ocimem_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/nios2_ocimem_pkg.sv
// rtl/nios2_ocimem_pkg.sv - shared types and constants for the OCI debug-memory controller
//
// Purpose: FSM state encoding, jdo field positions and the out-of-range read pattern,
//          shared by the controller top level and the debug RAM.
// Ports:   none (package).
package nios2_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    JRD,
    JRD_CAP,
    JWR,
    CRD,
    CRD_CAP
  } state_t;

  localparam int JDO_RD_NOW   = 34;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;

  localparam logic [31:0] OOR_PATTERN = 32'hDEADDEAD;

endpackage

// File: rtl/nios2_ocimem_ram.sv
// rtl/nios2_ocimem_ram.sv - single-port debug RAM with synchronous registered read
//
// Purpose: WORDS x 32 single-port block RAM. When en is high the word at addr is
//          registered onto q (read-before-write) and, if we is high, overwritten.
//          Contents are not reset.
// Ports:
//   clk    in   1   clock
//   en     in   1   port enable (read, and write when we=1)
//   we     in   1   write enable
//   addr   in   AW  word address
//   wdata  in   32  write data
//   q      out  32  read data, one clock after en
module nios2_ocimem_ram #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/nios2_jtag_ocimem_ctrl.sv
// rtl/nios2_jtag_ocimem_ctrl.sv - JTAG/CPU arbitrated controller for the OCI debug RAM
//
// Purpose: Executes host debug-RAM reads/writes requested through jdo and the ocimem
//          take_action strobes, returning MonDReg/monitor_ready/monitor_error, and serves
//          CPU Avalon-MM accesses to the same RAM. JTAG strobes win arbitration in IDLE.
// Build option: NIOS2_OCIMEM_AUTOINC_EN - when defined, MonAReg advances by one after
//          every completed JTAG read or write (out-of-range ones included); otherwise it
//          only changes on ocimem_a.
// Ports:
//   clk                      in   1       system clock
//   reset_n                  in   1       asynchronous active-low reset
//   jdo                      in   38      JTAG data, valid with the strobes
//   take_action_ocimem_a     in   1       address load / optional read
//   take_action_ocimem_b     in   1       write jdo[34:3] at MonAReg
//   take_no_action_ocimem_a  in   1       streaming read at MonAReg
//   avs_address              in   ADDR_W  CPU word address
//   avs_read                 in   1       CPU read request
//   avs_write                in   1       CPU write request
//   avs_writedata            in   32      CPU write data
//   avs_debugaccess          in   1       CPU write permitted only when 1
//   avs_readdata             out  32      CPU read data, valid when waitrequest low
//   avs_waitrequest          out  1       CPU stall
//   MonDReg                  out  32      monitor data register
//   monitor_ready            out  1       last JTAG operation complete
//   monitor_error            out  1       last JTAG operation was out of range
module nios2_jtag_ocimem_ctrl
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int RAM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [ADDR_W:0]   RAM_LIMIT = RAM_WORDS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] AREG_ONE  = 1;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] mon_areg;
  logic [ADDR_W-1:0] areg_next;
  logic              ready_pend;
  logic              rst_done;
  logic              j_in_range;
  logic              c_in_range;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;

  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              unused_bits;

  assign jdo_addr    = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data    = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  assign j_in_range  = ({1'b0, mon_areg} < RAM_LIMIT);
  assign c_in_range  = ({1'b0, avs_address} < RAM_LIMIT);
  assign unused_bits = ^{jdo[37:35], jdo[2:0]};

`ifdef NIOS2_OCIMEM_AUTOINC_EN
  // Natural ADDR_W-bit wrap takes 2^ADDR_W-1 back to 0.
  assign areg_next = mon_areg + AREG_ONE;
`else
  assign areg_next = mon_areg;
`endif

  nios2_ocimem_ram #(
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, RAM port steering and the Avalon response. A CPU write completes in
  // the IDLE cycle it is seen, so waitrequest is combinational on the request.
  // rst_done keeps the CPU stalled during reset and the first cycle after it.
  always_comb begin
    state_nxt       = state;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = mon_areg[RAM_AW-1:0];
    ram_wdata       = MonDReg;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_b) begin
          state_nxt = JWR;
        end else if (take_action_ocimem_a) begin
          if (jdo[JDO_RD_NOW]) begin
            state_nxt = JRD;
          end
        end else if (take_no_action_ocimem_a) begin
          state_nxt = JRD;
        end else if (rst_done && avs_write) begin
          avs_waitrequest = 1'b0;
          if (avs_debugaccess && c_in_range) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = avs_address[RAM_AW-1:0];
            ram_wdata = avs_writedata;
          end
        end else if (rst_done && avs_read) begin
          state_nxt = CRD;
        end
      end
      JRD: begin
        ram_en    = j_in_range;
        state_nxt = JRD_CAP;
      end
      JRD_CAP: begin
        state_nxt = IDLE;
      end
      JWR: begin
        ram_en    = j_in_range;
        ram_we    = j_in_range;
        state_nxt = IDLE;
      end
      CRD: begin
        ram_en    = c_in_range;
        ram_addr  = avs_address[RAM_AW-1:0];
        state_nxt = CRD_CAP;
      end
      CRD_CAP: begin
        avs_waitrequest = 1'b0;
        avs_readdata    = c_in_range ? ram_q : OOR_PATTERN;
        state_nxt       = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Monitor registers. An address-only ocimem_a drops monitor_ready for one cycle via
  // ready_pend; a strobe accepted in that cycle overrides the pending rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg       <= '0;
      mon_areg      <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      ready_pend    <= 1'b0;
      rst_done      <= 1'b0;
    end else begin
      rst_done   <= 1'b1;
      ready_pend <= 1'b0;
      if (ready_pend) begin
        monitor_ready <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (take_action_ocimem_b) begin
            MonDReg       <= jdo_data;
            monitor_ready <= 1'b0;
          end else if (take_action_ocimem_a) begin
            mon_areg      <= jdo_addr;
            monitor_ready <= 1'b0;
            ready_pend    <= ~jdo[JDO_RD_NOW];
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
          end
        end
        JRD_CAP: begin
          MonDReg       <= j_in_range ? ram_q : OOR_PATTERN;
          monitor_ready <= 1'b1;
          monitor_error <= ~j_in_range;
          mon_areg      <= areg_next;
        end
        JWR: begin
          monitor_ready <= 1'b1;
          monitor_error <= ~j_in_range;
          mon_areg      <= areg_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
